// File: rtl/addr_gen_pkg.sv
// Shared types and helpers for the window address sequencer: FSM state
// encoding, window-size derivation and the single-address formula.
package addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned data_length(input int unsigned kernel_size);
    return kernel_size * kernel_size;
  endfunction

  // Evaluated at 32 bits; callers truncate to the buffer address width.
  function automatic logic [31:0] window_addr(input logic [31:0] base,
                                              input logic [31:0] size,
                                              input logic [31:0] ox,
                                              input logic [31:0] oy,
                                              input logic [31:0] kx,
                                              input logic [31:0] ky);
    return base + (ox + kx) * size + (oy + ky);
  endfunction

endpackage

// File: rtl/window_addr_calc.sv
// Combinational expansion of one window position into its KERNEL_SIZE^2
// buffer addresses, element kx*KERNEL_SIZE+ky.
module window_addr_calc
  import addr_gen_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = 6,
  parameter  int unsigned KERNEL_SIZE = 3,
  localparam int unsigned DATA_LENGTH = data_length(KERNEL_SIZE)
) (
  input  logic [ADDR_WIDTH-1:0]                   start_addr_i,
  input  logic [ADDR_WIDTH-1:0]                   size_i,
  input  logic [ADDR_WIDTH-1:0]                   ox_i,
  input  logic [ADDR_WIDTH-1:0]                   oy_i,
  output logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  addr_o
);

  always_comb begin
    addr_o = '0;
    for (int kx = 0; kx < int'(KERNEL_SIZE); kx++) begin
      for (int ky = 0; ky < int'(KERNEL_SIZE); ky++) begin
        addr_o[kx*KERNEL_SIZE+ky] = ADDR_WIDTH'(window_addr(32'(start_addr_i), 32'(size_i),
                                                            32'(ox_i), 32'(oy_i),
                                                            32'(kx), 32'(ky)));
      end
    end
  end

endmodule

// File: rtl/window_address_sequencer.sv
// Walks every KERNEL_SIZE x KERNEL_SIZE window of a square map in row-major
// order, one window per handshake. Define ADDRGEN_STRIDE_EN for a programmable stride.
module window_address_sequencer
  import addr_gen_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH  = 6,
  parameter  int unsigned KERNEL_SIZE = 3,
  localparam int unsigned DATA_LENGTH = data_length(KERNEL_SIZE)
) (
  input  logic                                    i_clk,
  input  logic                                    i_nrst,
  input  logic                                    i_start,
  input  logic                                    i_reg_clear,
  input  logic [ADDR_WIDTH-1:0]                   i_start_addr,
  input  logic [ADDR_WIDTH-1:0]                   i_i_size,
  input  logic [ADDR_WIDTH-1:0]                   i_stride,
  input  logic                                    i_ready,
  output logic                                    o_valid,
  output logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  o_addr,
  output logic [ADDR_WIDTH-1:0]                   o_o_x,
  output logic [ADDR_WIDTH-1:0]                   o_o_y,
  output logic                                    o_busy,
  output logic                                    o_done
);

  // Two spare bits: position + stride + kernel can never wrap.
  localparam int unsigned          CW    = ADDR_WIDTH + 2;
  localparam logic [CW-1:0]        K_CMP = CW'(KERNEL_SIZE);

  state_e                                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]                   base_q, base_d;
  logic [ADDR_WIDTH-1:0]                   size_q, size_d;
  logic [ADDR_WIDTH-1:0]                   ox_q, ox_d;
  logic [ADDR_WIDTH-1:0]                   oy_q, oy_d;
  logic [ADDR_WIDTH-1:0]                   stride;
  logic [0:DATA_LENGTH-1][ADDR_WIDTH-1:0]  addr_q, addr_next;
  logic                                    load_addr;
  logic                                    y_fits, x_fits;

`ifdef ADDRGEN_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  assign stride = stride_q;
`else
  logic unused_stride;
  assign stride        = ADDR_WIDTH'(1);
  assign unused_stride = ^i_stride;
`endif

  assign y_fits = (CW'(oy_q) + CW'(stride) + K_CMP) <= CW'(size_q);
  assign x_fits = (CW'(ox_q) + CW'(stride) + K_CMP) <= CW'(size_q);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    base_d    = base_q;
    size_d    = size_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    load_addr = 1'b0;
`ifdef ADDRGEN_STRIDE_EN
    stride_d  = stride_q;
`endif
    if (i_reg_clear) begin
      state_d = IDLE;
      ox_d    = '0;
      oy_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            base_d = i_start_addr;
            size_d = i_i_size;
`ifdef ADDRGEN_STRIDE_EN
            stride_d = (i_stride == '0) ? ADDR_WIDTH'(1) : i_stride;
`endif
            ox_d = '0;
            oy_d = '0;
            if (CW'(i_i_size) < K_CMP) begin
              state_d = DONE;
            end else begin
              state_d   = RUN;
              load_addr = 1'b1;
            end
          end
        end
        RUN: begin
          if (i_ready) begin
            if (y_fits) begin
              oy_d      = oy_q + stride;
              load_addr = 1'b1;
            end else if (x_fits) begin
              ox_d      = ox_q + stride;
              oy_d      = '0;
              load_addr = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Addresses are precomputed from the next position so outputs stay registered.
  window_addr_calc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_calc (
    .start_addr_i (base_d),
    .size_i       (size_d),
    .ox_i         (ox_d),
    .oy_i         (oy_d),
    .addr_o       (addr_next)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      base_q  <= '0;
      size_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      // NOTE: the address bank is a small output register, not a RAM, so it is reset too.
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      if (i_reg_clear) begin
        addr_q <= '0;
      end else if (load_addr) begin
        addr_q <= addr_next;
      end
    end
  end

`ifdef ADDRGEN_STRIDE_EN
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end
`endif

  assign o_valid = (state_q == RUN);
  assign o_done  = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_addr  = addr_q;
  assign o_o_x   = ox_q;
  assign o_o_y   = oy_q;

endmodule

// File: tb/tb_window_address_sequencer.sv
// Self-checking bench: a list-of-windows reference model built from the
// sweep rules, randomized backpressure, clear, reset and busy-start stimulus.
module tb_window_address_sequencer;

  localparam int AW = 6;
  localparam int K  = 3;
  localparam int DL = K * K;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     i_start, i_reg_clear, i_ready;
  logic [AW-1:0]            i_start_addr, i_i_size, i_stride;
  logic                     o_valid, o_busy, o_done;
  logic [0:DL-1][AW-1:0]    o_addr;
  logic [AW-1:0]            o_o_x, o_o_y;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int x;
    int y;
  } win_t;

  always #5 clk = ~clk;

  window_address_sequencer #(
    .ADDR_WIDTH  (AW),
    .KERNEL_SIZE (K)
  ) dut (
    .i_clk        (clk),
    .i_nrst       (rst_n),
    .i_start      (i_start),
    .i_reg_clear  (i_reg_clear),
    .i_start_addr (i_start_addr),
    .i_i_size     (i_i_size),
    .i_stride     (i_stride),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_addr       (o_addr),
    .o_o_x        (o_o_x),
    .o_o_y        (o_o_y),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_stride(input int s);
`ifdef ADDRGEN_STRIDE_EN
    return (s == 0) ? 1 : s;
`else
    return 1;
`endif
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 64'(o_valid), 64'(0));
    check({tag, "_done"},  64'(o_done),  64'(0));
    check({tag, "_busy"},  64'(o_busy),  64'(0));
    check({tag, "_x"},     64'(o_o_x),   64'(0));
    check({tag, "_y"},     64'(o_o_y),   64'(0));
    check({tag, "_addr"},  64'(o_addr),  64'(0));
  endtask

  task automatic expect_window(input win_t w, input int base, input int size);
    logic [0:DL-1][AW-1:0] e;
    for (int kx = 0; kx < K; kx++)
      for (int ky = 0; ky < K; ky++)
        e[kx*K+ky] = AW'(base + (w.x + kx) * size + (w.y + ky));
    check("valid", 64'(o_valid), 64'(1));
    check("busy",  64'(o_busy),  64'(1));
    check("done_in_run", 64'(o_done), 64'(0));
    check("win_x", 64'(o_o_x),  64'(w.x));
    check("win_y", 64'(o_o_y),  64'(w.y));
    check("addr",  64'(o_addr), 64'(e));
  endtask

  // One sweep from IDLE. clear_at/stall_at name a handshake index (-1 = unused).
  task automatic sweep(input int base, input int size, input int stride, input int ready_pct,
                       input int clear_at, input int noise, input int stall_at);
    win_t q[$];
    int   st     = eff_stride(stride);
    int   hs     = 0;
    int   stalls = 0;
    int   budget = 20000;
    for (int xx = 0; xx + K <= size; xx += st)
      for (int yy = 0; yy + K <= size; yy += st)
        q.push_back('{x: xx, y: yy});
    i_start_addr = AW'(base);
    i_i_size     = AW'(size);
    i_stride     = AW'(stride);
    i_ready      = 1'b0;
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
    while (q.size() > 0) begin
      if (budget == 0) begin
        n_checks++;
        $display("FAIL sweep_timeout: %0d windows still expected", q.size());
        return;
      end
      budget--;
      expect_window(q[0], base, size);
      if (clear_at == hs) begin
        i_reg_clear = 1'b1;
        i_ready     = 1'b1;
        step();
        i_reg_clear = 1'b0;
        i_ready     = 1'b0;
        check_idle_zero("clr");
        step();
        check_idle_zero("clr_hold");
        return;
      end
      if (stall_at == hs && stalls < 3) begin
        i_ready = 1'b0;
        stalls++;
      end else begin
        i_ready = ($urandom_range(99) < ready_pct);
      end
      if (noise != 0) begin
        i_start      = ($urandom_range(3) == 0);
        i_start_addr = AW'($urandom);
        i_i_size     = AW'($urandom);
        i_stride     = AW'($urandom);
      end
      step();
      if (i_ready) begin
        void'(q.pop_front());
        hs++;
      end
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    check("end_valid", 64'(o_valid), 64'(0));
    check("end_done",  64'(o_done),  64'(1));
    check("end_busy",  64'(o_busy),  64'(1));
    step();
    check("idle_done",  64'(o_done),  64'(0));
    check("idle_busy",  64'(o_busy),  64'(0));
    check("idle_valid", 64'(o_valid), 64'(0));
  endtask

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_reg_clear  = 1'b0;
    i_ready      = 1'b0;
    i_start_addr = '0;
    i_i_size     = '0;
    i_stride     = '0;
    step();
    step();
    check_idle_zero("reset");
    rst_n = 1'b1;
    step();

    sweep(0, 4, 1, 100, -1, 0, -1);   // basic 4-window map
    sweep(8, 5, 2, 100, -1, 0, -1);   // strided
    sweep(8, 5, 0, 100, -1, 0, -1);   // stride 0 behaves as 1
    sweep(0, 4, 1, 100, -1, 0, 1);    // 3-cycle stall on window (0,1)
    sweep(0, 2, 1, 100, -1, 0, -1);   // degenerate map
    sweep(7, 0, 1, 100, -1, 0, -1);
    sweep(0, 3, 1, 100, -1, 0, -1);   // exactly one window
    sweep(0, 4, 1, 100, 2, 0, -1);    // clear on window (1,0) with ready
    sweep(0, 4, 1, 100, -1, 0, -1);   // fresh start reproduces the basic sweep
    sweep(60, 20, 3, 70, -1, 1, -1);  // address wrap-around, busy-start noise

    // Asynchronous reset mid-sweep.
    i_start_addr = AW'(5);
    i_i_size     = AW'(8);
    i_stride     = AW'(1);
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
    i_ready = 1'b1;
    step();
    step();
    i_ready = 1'b0;
    check("pre_rst_y",     64'(o_o_y),   64'(2));
    check("pre_rst_valid", 64'(o_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_idle_zero("async_rst");
    step();
    rst_n = 1'b1;
    step();
    check_idle_zero("post_rst");

    for (int i = 0; i < 12; i++) begin
      sweep(int'($urandom_range(63)), int'($urandom_range(14)), int'($urandom_range(5)),
            int'($urandom_range(100, 30)), -1, 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
